// File: rtl/acondicionador_entradas_pkg.sv
// Shared definitions for the input conditioning stage: Entrada bit layout,
// pad count, arbiter state encoding and small helpers.
package acondicionador_entradas_pkg;

    localparam int INICIO_BIT   = 0;
    localparam int ESTATICA_BIT = 1;
    localparam int PAD_LSB      = 2;
    localparam int NUM_PADS     = 5;
    localparam int PAD_IDX_W    = $clog2(NUM_PADS);

    typedef logic [PAD_IDX_W-1:0] pad_idx_t;

    typedef enum logic [1:0] {
        LIBRE     = 2'd0,
        BLOQUEADO = 2'd1,
        INICIO    = 2'd2
    } estado_t;

    // Counter width for a count of n: $clog2(n), never below 1 bit.
    function automatic int ancho_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [NUM_PADS-1:0] pad_onehot(input pad_idx_t idx);
        logic [NUM_PADS-1:0] r;
        r = NUM_PADS'(1) << idx;
        return r;
    endfunction

endpackage

// File: rtl/acondicionador_entradas_if.sv
// Sensor-to-paint-machine bundle: raw buttons/pads in, Entrada code and golpe out.
// master drives the raw sensor lines; slave is the conditioning stage.
interface acondicionador_entradas_if;
    import acondicionador_entradas_pkg::*;

    logic                btn_inicio;
    logic                btn_estatica;
    logic [NUM_PADS-1:0] pads;
    logic [6:0]          Entrada;
    logic                golpe;

    modport master (
        output btn_inicio,
        output btn_estatica,
        output pads,
        input  Entrada,
        input  golpe
    );

    modport slave (
        input  btn_inicio,
        input  btn_estatica,
        input  pads,
        output Entrada,
        output golpe
    );

endinterface

// File: rtl/acondicionador_entradas_antirrebote.sv
// One sensor line: 2-flop synchronizer followed by a stability debouncer.
// Ports: clk, reset (async, active-low), raw (async input), db (debounced level).
module acondicionador_entradas_antirrebote
    import acondicionador_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = ancho_contador(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          s;
    logic [CW-1:0] cnt;

    // The counter only runs while s disagrees with db, so any disagreement
    // shorter than DEBOUNCE_CYCLES is cleared before db can follow it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
            db   <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            s    <= meta;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == ULTIMO) begin
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/acondicionador_entradas.sv
// Input conditioning: debounces 7 sensor lines, arbitrates pad hits, and
// drives the registered Entrada code and golpe pulse. Ports: clk, reset, bus.
module acondicionador_entradas
    import acondicionador_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_MIN        = 2500000
) (
    input  logic                      clk,
    input  logic                      reset,
    acondicionador_entradas_if.slave  bus
);

    localparam int HW = ancho_contador(HOLD_MIN);
    localparam logic [HW-1:0] HOLD_CARGA = HW'(HOLD_MIN - 1);

    logic [6:0]          raw;
    logic [6:0]          db;
    logic                db_inicio;
    logic                db_estatica;
    logic [NUM_PADS-1:0] db_pads;

    assign raw = {bus.pads, bus.btn_estatica, bus.btn_inicio};

    for (genvar i = 0; i < 7; i++) begin : g_linea
        acondicionador_entradas_antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .db    (db[i])
        );
    end

    assign db_inicio   = db[INICIO_BIT];
    assign db_estatica = db[ESTATICA_BIT];
    assign db_pads     = db[PAD_LSB +: NUM_PADS];

    estado_t    estado, estado_sig;
    pad_idx_t   pad, pad_sig;
    logic [HW-1:0] hold, hold_sig;
    logic [6:0] entrada_q, entrada_sig;
    logic       golpe_q, golpe_sig;
    pad_idx_t   menor;
    logic       hay_pad;
    logic       pad_activo;

    // Lowest-index pad wins: scan downward so the last hit is the lowest.
    always_comb begin
        menor = '0;
        for (int k = NUM_PADS - 1; k >= 0; k--) begin
            if (db_pads[k]) begin
                menor = pad_idx_t'(k);
            end
        end
    end

    assign hay_pad    = |db_pads;
    assign pad_activo = |(db_pads & pad_onehot(pad));

    always_comb begin
        estado_sig = estado;
        pad_sig    = pad;
        hold_sig   = hold;
        golpe_sig  = 1'b0;
        if (db_inicio) begin
            estado_sig = INICIO;
            pad_sig    = '0;
            hold_sig   = '0;
        end else begin
            unique case (estado)
                LIBRE: begin
                    if (hay_pad) begin
                        estado_sig = BLOQUEADO;
                        pad_sig    = menor;
                        hold_sig   = HOLD_CARGA;
                        golpe_sig  = 1'b1;
                    end
                end
                BLOQUEADO: begin
                    if (hold != '0) begin
                        hold_sig = hold - HW'(1);
                    end
                    if (!pad_activo && hold == '0) begin
                        estado_sig = LIBRE;
                        pad_sig    = '0;
                    end
                end
                INICIO: begin
                    estado_sig = LIBRE;
                end
                default: begin
                    estado_sig = LIBRE;
                    pad_sig    = '0;
                    hold_sig   = '0;
                end
            endcase
        end
    end

    // Output code is built from the next state so Entrada, golpe and the
    // state register all change on the same edge.
    always_comb begin
        entrada_sig = '0;
        if (estado_sig == INICIO) begin
            entrada_sig[INICIO_BIT] = 1'b1;
        end else begin
            entrada_sig[ESTATICA_BIT] = db_estatica;
            if (estado_sig == BLOQUEADO) begin
                entrada_sig[PAD_LSB +: NUM_PADS] = pad_onehot(pad_sig);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= LIBRE;
            pad       <= '0;
            hold      <= '0;
            entrada_q <= '0;
            golpe_q   <= 1'b0;
        end else begin
            estado    <= estado_sig;
            pad       <= pad_sig;
            hold      <= hold_sig;
            entrada_q <= entrada_sig;
            golpe_q   <= golpe_sig;
        end
    end

    assign bus.Entrada = entrada_q;
    assign bus.golpe   = golpe_q;

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Directed bench for acondicionador_entradas with DEBOUNCE_CYCLES=4, HOLD_MIN=8.
// Expected (cycle, golpe, Entrada) entries are queued as stimulus is applied.
module tb_acondicionador_entradas;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   checking    = 1'b0;

    int         due_q[$];
    logic [7:0] exp_q[$];
    string      tag_q[$];

    acondicionador_entradas_if bus ();

    acondicionador_entradas #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_MIN(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int due, input logic [6:0] e,
                             input logic g, input string tag);
        due_q.push_back(due);
        exp_q.push_back({g, e});
        tag_q.push_back(tag);
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: golpe/Entrada observed %b/%b expected %b/%b",
                   tag, cyc, obs[7], obs[6:0], exp[7], exp[6:0]);
        end
    endtask

    function automatic bit legal(input logic [6:0] e);
        if (e == 7'b0000000 || e == 7'b0000001 || e == 7'b0000010)
            return 1'b1;
        return (e[0] == 1'b0) && ($countones(e[6:2]) == 1);
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int k = due_q.size() - 1; k >= 0; k--) begin
                if (due_q[k] == cyc) begin
                    check(tag_q[k], {bus.golpe, bus.Entrada}, exp_q[k]);
                    due_q.delete(k);
                    exp_q.delete(k);
                    tag_q.delete(k);
                end else if (due_q[k] < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s: expectation for cyc %0d missed, now %0d",
                             tag_q[k], due_q[k], cyc);
                    due_q.delete(k);
                    exp_q.delete(k);
                    tag_q.delete(k);
                end
            end
            vectors++;
            assert (legal(bus.Entrada)) else begin
                miscompares++;
                $error("FAIL legal @cyc %0d: Entrada observed %b, required a legal code",
                       cyc, bus.Entrada);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.btn_inicio   = 1'b0;
        bus.btn_estatica = 1'b0;
        bus.pads         = 5'b00000;

        // Reset with every input high: outputs clear asynchronously.
        #1;
        reset            = 1'b0;
        bus.btn_inicio   = 1'b1;
        bus.btn_estatica = 1'b1;
        bus.pads         = 5'b11111;
        #3;
        check("reset_async", {bus.golpe, bus.Entrada}, 8'h00);
        tick(3);
        check("reset_held", {bus.golpe, bus.Entrada}, 8'h00);
        bus.btn_inicio   = 1'b0;
        bus.btn_estatica = 1'b0;
        bus.pads         = 5'b00000;
        tick(1);
        reset    = 1'b1;
        checking = 1'b1;
        n = cyc;
        for (int i = 1; i <= 10; i++) expect_at(n + i, 7'b0, 1'b0, "idle");
        tick(12);

        // Single pad 2, 7-cycle latency, one-cycle golpe.
        n = cyc;
        bus.pads = 5'b00100;
        expect_at(n + 6, 7'b0000000, 1'b0, "pad2_pre");
        expect_at(n + 7, 7'b0010000, 1'b1, "pad2_lock");
        expect_at(n + 8, 7'b0010000, 1'b0, "pad2_golpe_end");
        tick(20);
        n = cyc;
        bus.pads = 5'b00000;
        expect_at(n + 6, 7'b0010000, 1'b0, "pad2_rel_pre");
        expect_at(n + 7, 7'b0000000, 1'b0, "pad2_rel");
        tick(10);

        // 3-cycle glitch on pad 0 must never reach Entrada.
        n = cyc;
        bus.pads = 5'b00001;
        for (int i = 1; i <= 12; i++) expect_at(n + i, 7'b0, 1'b0, "glitch");
        tick(3);
        bus.pads = 5'b00000;
        tick(11);

        // Static plus pads 1 and 4 together: lowest pad wins.
        n = cyc;
        bus.btn_estatica = 1'b1;
        bus.pads         = 5'b10010;
        expect_at(n + 6, 7'b0000000, 1'b0, "sim_pre");
        expect_at(n + 7, 7'b0001010, 1'b1, "sim_lock1");
        expect_at(n + 8, 7'b0001010, 1'b0, "sim_hold1");
        tick(20);
        n = cyc;
        bus.pads = 5'b10000;
        expect_at(n + 6, 7'b0001010, 1'b0, "sim_rel1_pre");
        expect_at(n + 7, 7'b0000010, 1'b0, "sim_libre");
        expect_at(n + 8, 7'b1000010, 1'b1, "sim_lock4");
        expect_at(n + 9, 7'b1000010, 1'b0, "sim_hold4");
        tick(12);
        n = cyc;
        bus.pads         = 5'b00000;
        bus.btn_estatica = 1'b0;
        expect_at(n + 7, 7'b0000000, 1'b0, "sim_clear");
        tick(10);

        // Pad 0 debounced high only 5 cycles: held exactly 8 cycles.
        n = cyc;
        bus.pads = 5'b00001;
        expect_at(n + 6, 7'b0000000, 1'b0, "hold_pre");
        expect_at(n + 7, 7'b0000100, 1'b1, "hold_lock");
        for (int i = 8; i <= 14; i++) expect_at(n + i, 7'b0000100, 1'b0, "hold_min");
        expect_at(n + 15, 7'b0000000, 1'b0, "hold_end");
        expect_at(n + 16, 7'b0000000, 1'b0, "hold_after");
        tick(5);
        bus.pads = 5'b00000;
        tick(15);

        // Start overrides a pad 3 lock, then pad 3 relocks.
        n = cyc;
        bus.pads = 5'b01000;
        expect_at(n + 7, 7'b0100000, 1'b1, "st_lock3");
        tick(12);
        n = cyc;
        bus.btn_inicio = 1'b1;
        expect_at(n + 6, 7'b0100000, 1'b0, "st_pre");
        expect_at(n + 7, 7'b0000001, 1'b0, "st_inicio");
        expect_at(n + 8, 7'b0000001, 1'b0, "st_inicio_hold");
        tick(10);
        n = cyc;
        bus.btn_inicio = 1'b0;
        expect_at(n + 6, 7'b0000001, 1'b0, "st_rel_pre");
        expect_at(n + 7, 7'b0000000, 1'b0, "st_libre");
        expect_at(n + 8, 7'b0100000, 1'b1, "st_relock");
        expect_at(n + 9, 7'b0100000, 1'b0, "st_relock_hold");
        tick(12);
        n = cyc;
        bus.pads = 5'b00000;
        expect_at(n + 6, 7'b0100000, 1'b0, "st_pad_rel_pre");
        expect_at(n + 7, 7'b0000000, 1'b0, "st_pad_rel");
        tick(10);

        // Start and pad 1 together from LIBRE: start wins, no golpe.
        n = cyc;
        bus.btn_inicio = 1'b1;
        bus.pads       = 5'b00010;
        expect_at(n + 6, 7'b0000000, 1'b0, "both_pre");
        expect_at(n + 7, 7'b0000001, 1'b0, "both_inicio");
        expect_at(n + 8, 7'b0000001, 1'b0, "both_inicio_hold");
        tick(10);
        n = cyc;
        bus.btn_inicio = 1'b0;
        expect_at(n + 6, 7'b0000001, 1'b0, "both_rel_pre");
        expect_at(n + 7, 7'b0000000, 1'b0, "both_libre");
        expect_at(n + 8, 7'b0001000, 1'b1, "both_lock1");
        expect_at(n + 9, 7'b0001000, 1'b0, "both_hold1");
        tick(11);

        // Reset mid-lock with pad 1 held: clears at once, relocks later.
        #2;
        reset = 1'b0;
        #1;
        check("reset_midlock", {bus.golpe, bus.Entrada}, 8'h00);
        tick(2);
        reset = 1'b1;
        n = cyc;
        expect_at(n + 6, 7'b0000000, 1'b0, "rst_relock_pre");
        expect_at(n + 7, 7'b0001000, 1'b1, "rst_relock");
        expect_at(n + 8, 7'b0001000, 1'b0, "rst_relock_hold");
        tick(12);
        bus.pads = 5'b00000;

        for (int i = 0; i < 50 && due_q.size() > 0; i++) tick(1);
        if (due_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations pending, required 0",
                     due_q.size());
        end
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acondicionador_entradas.md
# acondicionador_entradas

Input conditioning stage between the raw drum-pad/button sensors and the paint state machine. Synchronizes and debounces seven active-high sensor lines, arbitrates simultaneous pad hits, and emits the clean 7-bit `Entrada` code the paint machine decodes. It also emits a one-cycle `golpe` pulse per accepted pad hit for the scoring logic. The block guarantees that `Entrada` only ever carries one of the codes the paint machine recognizes, or zero.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable synchronized cycles required before a debounced line changes (5 ms at 50 MHz).
- `HOLD_MIN`, 2500000: minimum cycles a locked pad stays on `Entrada` after lock, even if released earlier (50 ms).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_inicio`  in  1  raw start button, asynchronous, active-high.
- `btn_estatica`  in  1  raw static-band button, asynchronous, active-high.
- `pads`  in  5  raw drum pads [4:0], asynchronous, active-high; pad i maps to band i+1.
- `Entrada`  out  7  registered code to the paint machine: bit0 start, bit1 static, bits[6:2] pad one-hot.
- `golpe`  out  1  registered one-cycle pulse on each new pad lock.

## Operation
- Per line: 2-flop synchronizer, then debouncer. The counter increments while the synchronized value s differs from debounced value db, and clears when they are equal. When the counter reaches `DEBOUNCE_CYCLES-1` and s≠db, db <= s and the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` never reaches db.
- Arbiter FSM states:
  - LIBRE: no pad locked.
  - BLOQUEADO: pad index p locked, hold counter running.
  - INICIO: start asserted.
- Start priority: in any state, debounced start high → INICIO. `Entrada` = 7'b0000001, pad lock dropped, `golpe` = 0. Debounced start low in INICIO → LIBRE.
- LIBRE: if any debounced pad is high, lock the lowest-index high pad p. Load the hold counter with `HOLD_MIN-1`, pulse `golpe`, go to BLOQUEADO.
- BLOQUEADO: other pads are ignored. The hold counter decrements to 0 and saturates there. Return to LIBRE only when pad p is debounced low and the counter is 0. A new lock can occur on the cycle after the return to LIBRE.
- Outside INICIO: `Entrada[1]` = debounced static, `Entrada[6:2]` = one-hot of p in BLOQUEADO (else 0), `Entrada[0]` = 0.
- Legal `Entrada` values: 0, 7'b0000001, 7'b0000010, single pad bit, single pad bit with bit1. No other value may ever appear.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No wrap in either counter.

## Timing
- Reset (async assert, sync-released by the clock): all synchronizer flops, db, and counters = 0; FSM = LIBRE; `Entrada` = 0; `golpe` = 0.
- Latency from raw edge to db change: 2 + `DEBOUNCE_CYCLES` cycles.
- Latency from db change to `Entrada`/`golpe`: 1 cycle (both registered).
- `golpe` is high exactly one cycle, coincident with the first cycle `Entrada` shows the new pad.
- Simultaneous start and pad in LIBRE: start wins, no lock, no `golpe`.
- Reset mid-lock: `Entrada` goes to 0 immediately (async); a pad held through reset relocks after full debounce latency.

## Structure
- Shared package: `Entrada` bit-position constants (INICIO_BIT=0, ESTATICA_BIT=1, PAD_LSB=2), pad count 5, FSM state encoding.
- Sub-module `antirrebote`: one synchronizer plus debouncer, parameterized by `DEBOUNCE_CYCLES`. Instantiated 7 times; the top level holds the arbiter FSM, hold counter, and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `HOLD_MIN`=8.
- Reset: assert `reset`=0 with all inputs high → `Entrada`=0 and `golpe`=0 asynchronously. Release with inputs low → both remain 0.
- Single pad: `pads`=5'b00100 held 20 cycles → `Entrada`=7'b0010000 7 cycles after the raw edge, with `golpe` high for that one cycle only. Release → `Entrada`=0 7 cycles after release.
- Glitch rejection: `pads[0]` pulsed for 3 cycles → `Entrada` stays 0 and `golpe` stays 0.
- Simultaneous pads with static: `btn_estatica`=1, `pads`=5'b10010 in the same cycle → `Entrada`=7'b0001010. Release `pads[1]` while `pads[4]` stays high → `Entrada`=7'b0000010, then `Entrada`=7'b1000010 with a second `golpe`.
- Minimum hold: pad 0 pressed for 5 debounced cycles → `Entrada` bit2 stays high for exactly 8 cycles from lock.
- Start override: during a pad 3 lock, assert `btn_inicio` → `Entrada`=7'b0000001, with no illegal intermediate code. Release start with pad 3 still held → relock to `Entrada`=7'b0100000 with a `golpe` pulse.
